wb_result_stage: RTL and testbench

// Registered writeback-result stage for the RISC-V core: picks the register-file write value from ALU, load data, PC+4 or immediate.

---
 rtl/wb_result_stage.sv | 135 +++++++++++++
 tb/tb_wb_result_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_result_stage.sv
// Registered writeback-result stage: selects the register-file write value
// (ALU / load / PC+4 / immediate), extends load data and drives a valid/ready writeback port.
module wb_result_stage #(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_src,
    input  logic [2:0]       in_funct3,
    input  logic [REG_W-1:0] in_rd,
    input  logic             in_we,
    input  logic [XLEN-1:0]  alu_result,
    input  logic [XLEN-1:0]  pc_plus4,
    input  logic [XLEN-1:0]  imm,
    input  logic             mem_rvalid,
    output logic             mem_rready,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [REG_W-1:0] out_rd,
    output logic             out_we,
    output logic [XLEN-1:0]  out_data,
    output logic             out_misalign
);

    localparam int OFFW = $clog2(XLEN / 8);
    localparam logic [1:0] SRC_MEM = 2'd1;

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t           state, state_nxt;
    logic             free, in_acc, mem_acc;
    logic [REG_W-1:0] ld_rd;
    logic             ld_we;
    logic [2:0]       ld_f3;
    logic [OFFW-1:0]  ld_off;
    logic [XLEN-1:0]  shifted, ld_data, nl_data;
    logic             ld_mis;

    assign free    = !out_valid || out_ready;
    assign in_acc  = in_valid && in_ready;
    assign mem_acc = mem_rvalid && mem_rready;

    always_ff @(posedge clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (in_acc && in_src == SRC_MEM) state_nxt = WAIT_MEM;
            WAIT_MEM: if (mem_acc) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state == IDLE) && free;
        mem_rready = (state == WAIT_MEM) && free;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            ld_rd  <= '0;
            ld_we  <= 1'b0;
            ld_f3  <= '0;
            ld_off <= '0;
        end else if (in_acc && in_src == SRC_MEM) begin
            ld_rd  <= in_rd;
            ld_we  <= in_we;
            ld_f3  <= in_funct3;
            ld_off <= alu_result[OFFW-1:0];
        end
    end

    assign shifted = mem_rdata >> {ld_off, 3'b000};

    // Misaligned or unsupported funct3 both report through ld_mis with zero data.
    always_comb begin
        ld_data = '0;
        ld_mis  = 1'b0;
        case (ld_f3)
            3'b000: ld_data = XLEN'($signed(shifted[7:0]));
            3'b001: if (ld_off[0]) ld_mis = 1'b1;
                    else ld_data = XLEN'($signed(shifted[15:0]));
            3'b010: if (ld_off[1:0] != 2'b00) ld_mis = 1'b1;
                    else ld_data = XLEN'($signed(shifted[31:0]));
            3'b011: if (XLEN == 64 && ld_off == '0) ld_data = shifted;
                    else ld_mis = 1'b1;
            3'b100: ld_data = XLEN'(shifted[7:0]);
            3'b101: if (ld_off[0]) ld_mis = 1'b1;
                    else ld_data = XLEN'(shifted[15:0]);
            3'b110: if (XLEN == 64 && ld_off[1:0] == 2'b00) ld_data = XLEN'(shifted[31:0]);
                    else ld_mis = 1'b1;
            default: ld_mis = 1'b1;
        endcase
    end

    always_comb begin
        case (in_src)
            2'd2:    nl_data = pc_plus4;
            2'd3:    nl_data = imm;
            default: nl_data = alu_result;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            out_valid    <= 1'b0;
            out_rd       <= '0;
            out_we       <= 1'b0;
            out_data     <= '0;
            out_misalign <= 1'b0;
        end else if (in_acc && in_src != SRC_MEM) begin
            out_valid    <= 1'b1;
            out_rd       <= in_rd;
            out_we       <= in_we && (in_rd != '0);
            out_data     <= nl_data;
            out_misalign <= 1'b0;
        end else if (mem_acc) begin
            out_valid    <= 1'b1;
            out_rd       <= ld_rd;
            out_we       <= ld_we && (ld_rd != '0) && !ld_mis;
            out_data     <= ld_mis ? '0 : ld_data;
            out_misalign <= ld_mis;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_result_stage.sv
// Scoreboard bench for wb_result_stage: the driver pushes expected writebacks,
// a monitor pops and compares them on each output handshake.
module tb_wb_result_stage;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    logic             clk, Reset;
    logic             in_valid, in_ready, in_we;
    logic [1:0]       in_src;
    logic [2:0]       in_funct3;
    logic [REG_W-1:0] in_rd;
    logic [XLEN-1:0]  alu_result, pc_plus4, imm;
    logic             mem_rvalid, mem_rready;
    logic [XLEN-1:0]  mem_rdata;
    logic             out_valid, out_ready, out_we, out_misalign;
    logic [REG_W-1:0] out_rd;
    logic [XLEN-1:0]  out_data;

    wb_result_stage #(.XLEN(XLEN), .REG_W(REG_W)) dut (
        .clk(clk), .Reset(Reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_src(in_src),
        .in_funct3(in_funct3), .in_rd(in_rd), .in_we(in_we),
        .alu_result(alu_result), .pc_plus4(pc_plus4), .imm(imm),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_we(out_we), .out_data(out_data), .out_misalign(out_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [XLEN-1:0]  data;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             mis;
        int unsigned      cyc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passed = 0;

    // Reference state: one outstanding load at most
    bit               pend = 0;
    logic [REG_W-1:0] p_rd;
    logic             p_we;
    logic [2:0]       p_f3;
    int unsigned      p_off;
    bit               acc_in, acc_mem;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    endtask

    function automatic exp_t ref_load(input logic [2:0] f3, input int unsigned off,
                                      input logic [XLEN-1:0] rdata,
                                      input logic [REG_W-1:0] rd, input logic we);
        exp_t        e;
        logic [63:0] raw, mask;
        int unsigned nbytes;
        bit          legal;
        nbytes = 1 << f3[1:0];
        legal  = (f3 != 3'b111) && (nbytes * 8 <= XLEN) && !(f3 == 3'b110 && XLEN == 32);
        e.rd   = rd;
        e.cyc  = 0;
        if (!legal || (off % nbytes) != 0) begin
            e.data = '0; e.mis = 1'b1; e.we = 1'b0;
        end else begin
            raw  = 64'(rdata) >> (8 * off);
            mask = (nbytes == 8) ? '1 : ((64'd1 << (8 * nbytes)) - 64'd1);
            raw  = raw & mask;
            if (!f3[2] && raw[8*nbytes-1]) raw = raw | ~mask;
            e.data = raw[XLEN-1:0];
            e.mis  = 1'b0;
            e.we   = we && (rd != 0);
        end
        return e;
    endfunction

    // Called right after inputs are applied at a falling edge
    task automatic eval_cycle();
        bit   fr;
        exp_t e;
        #1;
        acc_in  = in_valid && in_ready;
        acc_mem = mem_rvalid && mem_rready;
        fr = !out_valid || out_ready;
        check("in_ready", in_ready, !pend && fr);
        check("mem_rready", mem_rready, pend && fr);
        if (acc_mem) begin
            e = ref_load(p_f3, p_off, mem_rdata, p_rd, p_we);
            e.cyc = cyc + 1;
            sbq.push_back(e);
            pend = 0;
        end
        if (acc_in) begin
            if (in_src == 2'd1) begin
                pend = 1; p_rd = in_rd; p_we = in_we; p_f3 = in_funct3;
                p_off = alu_result % (XLEN / 8);
            end else begin
                e.data = (in_src == 2'd2) ? pc_plus4 : (in_src == 2'd3) ? imm : alu_result;
                e.rd   = in_rd;
                e.we   = in_we && (in_rd != 0);
                e.mis  = 1'b0;
                e.cyc  = cyc + 1;
                sbq.push_back(e);
            end
        end
    endtask

    task automatic send(input logic [1:0] src, input logic [2:0] f3, input logic [REG_W-1:0] rd,
                        input logic we, input logic [XLEN-1:0] alu, input logic [XLEN-1:0] pc,
                        input logic [XLEN-1:0] im);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_src = src; in_funct3 = f3; in_rd = rd; in_we = we;
            alu_result = alu; pc_plus4 = pc; imm = im; mem_rvalid = 1'b0;
            eval_cycle();
            if (acc_in) return;
        end
        check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0; mem_rvalid = 1'b0;
            eval_cycle();
        end
    endtask

    task automatic respond(input logic [XLEN-1:0] data, input int delay);
        idle(delay);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            in_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = data;
            eval_cycle();
            if (acc_mem) return;
        end
        check("respond_timeout", 0, 1);
    endtask

    // Monitor: scoreboard pops, latency and stall-stability checks
    initial begin
        logic             pv = 0, phs = 0, pstall = 0;
        logic [XLEN-1:0]  pdata = '0;
        logic [REG_W-1:0] prd = '0;
        logic             pwe = 0, pmis = 0;
        int unsigned      vis = 0;
        exp_t             e;
        forever begin
            @(negedge clk);
            #2;
            if (Reset) begin
                pv = 0; phs = 0; pstall = 0;
                continue;
            end
            if (pstall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_hold", {out_data, out_rd, out_we, out_misalign}, {pdata, prd, pwe, pmis});
            end
            if (out_valid && (!pv || phs)) vis = cyc;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_output", {out_data, out_rd}, 0);
                end else begin
                    e = sbq.pop_front();
                    check("wb_item", {out_data, out_rd, out_we, out_misalign}, {e.data, e.rd, e.we, e.mis});
                    check("latency", vis, e.cyc);
                end
            end
            pv = out_valid; phs = out_valid && out_ready; pstall = out_valid && !out_ready;
            pdata = out_data; prd = out_rd; pwe = out_we; pmis = out_misalign;
        end
    end

    initial begin
        Reset = 1'b1; in_valid = 0; in_src = 0; in_funct3 = 0; in_rd = 0; in_we = 0;
        alu_result = 0; pc_plus4 = 0; imm = 0; mem_rvalid = 0; mem_rdata = 0; out_ready = 1;
        repeat (3) @(negedge clk);
        @(negedge clk);
        Reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_out_we", out_we, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_misalign", out_misalign, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_mem_rready", mem_rready, 0);

        // Directed cases
        send(2'd0, 3'd0, 5'd5, 1'b1, 32'h1234, 0, 0);
        idle(1);
        send(2'd1, 3'b000, 5'd6, 1'b1, 32'h1003, 0, 0);
        respond(32'h80FF_0000, 1);
        send(2'd1, 3'b101, 5'd7, 1'b1, 32'h2002, 0, 0);
        respond(32'hBEEF_1234, 0);
        send(2'd1, 3'b001, 5'd8, 1'b1, 32'h2001, 0, 0);
        respond(32'hBEEF_1234, 0);
        idle(2);

        // Stall with a request waiting, then release
        out_ready = 1'b0;
        send(2'd3, 3'd0, 5'd9, 1'b1, 0, 0, 32'hABCD_0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_src = 2'd0; in_rd = 5'd10; in_we = 1'b1; alu_result = 32'h55;
            eval_cycle();
            check("stall_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        eval_cycle();
        check("release_accept", acc_in, 1);
        idle(1);
        send(2'd2, 3'd0, 5'd0, 1'b1, 0, 32'h104, 0);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (!in_valid || acc_in) begin
                in_valid   = ($urandom_range(0, 3) != 0);
                in_src     = 2'($urandom_range(0, 3));
                in_funct3  = 3'($urandom_range(0, 7));
                in_rd      = REG_W'($urandom_range(0, 31));
                in_we      = ($urandom_range(0, 3) != 0);
                alu_result = $urandom; pc_plus4 = $urandom; imm = $urandom;
            end
            if (!mem_rvalid || acc_mem) begin
                mem_rvalid = ($urandom_range(0, 1) != 0);
                mem_rdata  = $urandom;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            eval_cycle();
        end

        // Drain
        out_ready = 1'b1;
        for (int i = 0; i < 60 && (pend || sbq.size() != 0 || out_valid); i++) begin
            @(negedge clk);
            in_valid = 1'b0; mem_rvalid = pend; mem_rdata = $urandom;
            eval_cycle();
        end
        check("drained", sbq.size(), 0);

        // Reset while waiting for load data; the late response must be ignored
        send(2'd1, 3'b010, 5'd11, 1'b1, 32'h3000, 0, 0);
        idle(1);
        @(negedge clk);
        Reset = 1'b1; in_valid = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        Reset = 1'b0; pend = 0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_in_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_rvalid = 1'b1;
            eval_cycle();
        end
        check("late_resp_ignored", out_valid, 0);
        check("final_queue_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
